// File: rtl/bus_hold_arbiter.sv
// Round-robin arbiter that borrows the 8088 bus through HOLD/HLDA and steers
// the granted master's RAM port onto the shared RAM, otherwise the CPU's.
module bus_hold_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 14,
    parameter int unsigned DW   = 8,
    parameter int unsigned GAP  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      gnt,
    output logic                 cpu_hold,
    input  logic                 cpu_hlda,
    input  logic [AW-1:0]        cpu_ram_addr,
    input  logic [DW-1:0]        cpu_ram_data,
    input  logic                 cpu_ram_wren,
    input  logic [NREQ*AW-1:0]   m_ram_addr,
    input  logic [NREQ*DW-1:0]   m_ram_data,
    input  logic [NREQ-1:0]      m_ram_wren,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_data,
    output logic                 ram_wren,
    output logic                 busy
);

    localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StHoldWait = 3'd1;
    localparam logic [2:0] StGrant    = 3'd2;
    localparam logic [2:0] StRelease  = 3'd3;
    localparam logic [2:0] StGapWait  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [LW-1:0]   winner_q, winner_d;
    logic [LW-1:0]   last_q, last_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            hold_q, hold_d;
    logic [3:0]      gap_q, gap_d;

    logic [LW-1:0]   pick;
    logic [NREQ-1:0] req_sh, gnt_sh;
    logic            req_w, sel_m;

    // First set request searching upward from last+1, wrapping modulo NREQ.
    function automatic logic [LW-1:0] next_winner(input logic [NREQ-1:0] r,
                                                  input logic [LW-1:0]   last);
        logic [LW-1:0]   w;
        logic            found;
        logic [NREQ-1:0] sh;
        int unsigned     idx;
        w     = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last) + k) % NREQ;
            sh  = r >> idx;
            if (!found && sh[0]) begin
                w     = LW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        pick   = next_winner(req, last_q);
        req_sh = req >> winner_q;
        req_w  = req_sh[0];
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        hold_d   = hold_q;
        gap_d    = gap_q;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    winner_d = pick;
                    hold_d   = 1'b1;
                    state_d  = StHoldWait;
                end
            end
            StHoldWait: begin
                if (cpu_hlda) begin
                    if (req_w) begin
                        gnt_d   = NREQ'(1) << winner_q;
                        last_d  = winner_q;
                        state_d = StGrant;
                    end else begin
                        // Abandoned request: give the bus back without advancing last.
                        hold_d  = 1'b0;
                        state_d = StRelease;
                    end
                end
            end
            StGrant: begin
                if (!cpu_hlda || !req_w) begin
                    gnt_d   = '0;
                    hold_d  = 1'b0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (!cpu_hlda) begin
                    if (GAP == 0) begin
                        state_d = StIdle;
                    end else begin
                        gap_d   = 4'(GAP);
                        state_d = StGapWait;
                    end
                end
            end
            StGapWait: begin
                gap_d = gap_q - 4'd1;
                if (gap_q <= 4'd1) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                hold_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            winner_q <= '0;
            last_q   <= LW'(NREQ - 1);
            gnt_q    <= '0;
            hold_q   <= 1'b0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            hold_q   <= hold_d;
            gap_q    <= gap_d;
        end
    end

    // The CPU may never write while it has floated the bus.
    always_comb begin
        gnt_sh = gnt_q >> winner_q;
        sel_m  = (state_q == StGrant) && gnt_sh[0];
        if (sel_m) begin
            ram_addr = m_ram_addr[32'(winner_q) * AW +: AW];
            ram_data = m_ram_data[32'(winner_q) * DW +: DW];
            ram_wren = m_ram_wren[winner_q];
        end else begin
            ram_addr = cpu_ram_addr;
            ram_data = cpu_ram_data;
            ram_wren = cpu_ram_wren & ~cpu_hlda;
        end
    end

    assign gnt      = gnt_q;
    assign cpu_hold = hold_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Directed bench: stimulus queues the expected bus state for every grant edge,
// a monitor compares on each gnt change; other checks are made in line.
module tb_bus_hold_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 14;
    localparam int unsigned DW   = 8;
    localparam int unsigned GAP  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      gnt;
    logic                 cpu_hold;
    logic                 cpu_hlda;
    logic [AW-1:0]        cpu_ram_addr;
    logic [DW-1:0]        cpu_ram_data;
    logic                 cpu_ram_wren;
    logic [NREQ*AW-1:0]   m_ram_addr;
    logic [NREQ*DW-1:0]   m_ram_data;
    logic [NREQ-1:0]      m_ram_wren;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_data;
    logic                 ram_wren;
    logic                 busy;

    bus_hold_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .GAP(GAP)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .gnt          (gnt),
        .cpu_hold     (cpu_hold),
        .cpu_hlda     (cpu_hlda),
        .cpu_ram_addr (cpu_ram_addr),
        .cpu_ram_data (cpu_ram_data),
        .cpu_ram_wren (cpu_ram_wren),
        .m_ram_addr   (m_ram_addr),
        .m_ram_data   (m_ram_data),
        .m_ram_wren   (m_ram_wren),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [1:0]   gnt;
        logic         hold;
        logic         busy;
        logic [13:0]  addr;
        logic [7:0]   data;
        logic         wren;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic mon_en  = 1'b0;
    logic auto_hlda = 1'b1;
    logic [2:0] hist = '0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic void push(input string n, input logic [1:0] g, input logic h,
                                 input logic b, input logic [13:0] a, input logic [7:0] d,
                                 input logic w);
        exp_t e;
        e.name = n; e.gnt = g; e.hold = h; e.busy = b; e.addr = a; e.data = d; e.wren = w;
        sb_q.push_back(e);
    endfunction

    // Master 0: 0x1234/0x5A/wren 1, master 1: 0x0ABC/0x33/wren 0.
    function automatic void push_grant(input string n, input int w);
        if (w == 0) push(n, 2'b01, 1'b1, 1'b1, 14'h1234, 8'h5A, 1'b1);
        else        push(n, 2'b10, 1'b1, 1'b1, 14'h0ABC, 8'h33, 1'b0);
    endfunction

    function automatic void push_cpu(input string n, input logic b, input logic w);
        push(n, 2'b00, 1'b0, b, 14'h0111, 8'h11, w);
    endfunction

    function automatic logic sel_val(input int sel);
        case (sel)
            0:       return cpu_hold;
            1:       return cpu_hlda;
            2:       return busy;
            default: return |gnt;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic wait_until(input string name, input int sel, input logic v);
        for (int i = 0; i < 64; i++) begin
            if (sel_val(sel) === v) break;
            tick(1);
        end
        check(name, sel_val(sel), v);
    endtask

    // CPU model: HLDA follows HOLD three cycles later.
    initial begin
        cpu_hlda = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            hist = {hist[1:0], cpu_hold};
            if (auto_hlda) cpu_hlda = hist[2];
        end
    end

    // Monitor: every gnt change is an output event to be matched against the queue.
    initial begin
        logic [1:0] prev_gnt;
        exp_t e;
        prev_gnt = '0;
        forever begin
            @(negedge clk);
            if (mon_en && gnt !== prev_gnt) begin
                if (sb_q.size() == 0) begin
                    check("unexpected gnt change", gnt, prev_gnt);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, " gnt"}, gnt, e.gnt);
                    check({e.name, " hold"}, cpu_hold, e.hold);
                    check({e.name, " busy"}, busy, e.busy);
                    check({e.name, " ram_addr"}, ram_addr, e.addr);
                    check({e.name, " ram_data"}, ram_data, e.data);
                    check({e.name, " ram_wren"}, ram_wren, e.wren);
                end
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int low;
        logic seen;
        int w;
        int cnt;
        int rr_w[3];
        rr_w = '{1, 0, 1};

        rst          = 1'b1;
        req          = '0;
        cpu_ram_addr = 14'h0111;
        cpu_ram_data = 8'h11;
        cpu_ram_wren = 1'b0;
        m_ram_addr   = {14'h0ABC, 14'h1234};
        m_ram_data   = {8'h33, 8'h5A};
        m_ram_wren   = 2'b01;
        tick(2);
        check("reset gnt", gnt, 2'b00);
        check("reset hold", cpu_hold, 1'b0);
        check("reset busy", busy, 1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick(1);

        // Single master
        push_grant("single grant", 0);
        req = 2'b01;
        tick(1);
        check("single hold next cycle", cpu_hold, 1'b1);
        check("single busy next cycle", busy, 1'b1);
        wait_until("single hlda rises", 1, 1'b1);
        check("single no gnt before hlda sampled", gnt, 2'b00);
        tick(1);
        check("single gnt after hlda", gnt, 2'b01);
        push_cpu("single release", 1'b1, 1'b0);
        req = 2'b00;
        tick(1);
        check("single hold drop", cpu_hold, 1'b0);
        wait_until("single idle", 2, 1'b0);

        // Round-robin with both masters requesting
        for (int k = 0; k < 3; k++) begin
            w = rr_w[k];
            push_grant($sformatf("rr grant %0d", k), w);
            if (k == 0) req = 2'b11;
            wait_until($sformatf("rr gnt %0d", k), 3, 1'b1);
            tick(2);
            push_cpu($sformatf("rr release %0d", k), 1'b1, 1'b0);
            req[w] = 1'b0;
            tick(1);
            check($sformatf("rr hold drop %0d", k), cpu_hold, 1'b0);
            if (k < 2) req[w] = 1'b1;
            else       req    = 2'b00;
            cpu_ram_wren = 1'b1;
            if (k < 2) begin
                low  = 1;
                seen = 1'b0;
                for (int i = 0; i < 60; i++) begin
                    if (cpu_hold) break;
                    if (!seen && !cpu_hlda) begin
                        check("rr gap cpu wren", ram_wren, 1'b1);
                        check("rr gap cpu addr", ram_addr, 14'h0111);
                        seen = 1'b1;
                    end
                    tick(1);
                    low++;
                end
                check($sformatf("rr hold low >= GAP+1 (%0d)", low), low >= GAP + 1, 1'b1);
            end else begin
                wait_until("rr final idle", 2, 1'b0);
            end
            cpu_ram_wren = 1'b0;
        end

        // Abandoned request: last stays at 1, so master 0 wins next
        req = 2'b01;
        tick(1);
        req = 2'b00;
        check("abandon hold up", cpu_hold, 1'b1);
        wait_until("abandon hlda rises", 1, 1'b1);
        check("abandon hold kept until hlda", cpu_hold, 1'b1);
        tick(1);
        check("abandon hold drop", cpu_hold, 1'b0);
        check("abandon no gnt", gnt, 2'b00);
        wait_until("abandon idle", 2, 1'b0);
        push_grant("abandon follow grant", 0);
        req = 2'b11;
        wait_until("abandon follow gnt", 3, 1'b1);
        tick(1);
        push_cpu("abandon follow release", 1'b1, 1'b0);
        req = 2'b00;
        wait_until("abandon follow idle", 2, 1'b0);

        // CPU write masking while the CPU is floating
        push_grant("mask grant", 1);
        cpu_ram_wren = 1'b1;
        req = 2'b10;
        wait_until("mask hlda rises", 1, 1'b1);
        check("mask wren in hold_wait", ram_wren, 1'b0);
        check("mask addr in hold_wait", ram_addr, 14'h0111);
        tick(1);
        push_cpu("mask release", 1'b1, 1'b0);
        req = 2'b00;
        tick(1);
        wait_until("mask hlda falls", 1, 1'b0);
        check("mask wren follows high", ram_wren, 1'b1);
        cpu_ram_wren = 1'b0;
        #1;
        check("mask wren follows low", ram_wren, 1'b0);
        wait_until("mask idle", 2, 1'b0);

        // Reset mid-grant
        push_grant("reset grant", 0);
        req = 2'b01;
        wait_until("reset gnt up", 3, 1'b1);
        tick(1);
        push_cpu("reset clear", 1'b0, 1'b0);
        rst = 1'b1;
        req = 2'b00;
        tick(1);
        check("reset mid gnt", gnt, 2'b00);
        check("reset mid hold", cpu_hold, 1'b0);
        check("reset mid busy", busy, 1'b0);
        rst = 1'b0;
        wait_until("reset hlda falls", 1, 1'b0);
        push_grant("post reset grant", 1);
        req = 2'b10;
        wait_until("post reset hold", 0, 1'b1);
        check("post reset no gnt before hlda", gnt, 2'b00);
        wait_until("post reset hlda", 1, 1'b1);
        check("post reset no gnt yet", gnt, 2'b00);
        tick(1);
        check("post reset gnt", gnt, 2'b10);
        push_cpu("post reset release", 1'b1, 1'b0);
        req = 2'b00;
        wait_until("post reset idle", 2, 1'b0);

        // HLDA protocol error during grant
        push_grant("perr grant", 0);
        req = 2'b01;
        wait_until("perr gnt up", 3, 1'b1);
        tick(1);
        push_cpu("perr clear", 1'b1, 1'b1);
        auto_hlda    = 1'b0;
        cpu_hlda     = 1'b0;
        cpu_ram_wren = 1'b1;
        tick(1);
        check("perr gnt", gnt, 2'b00);
        check("perr hold", cpu_hold, 1'b0);
        req = 2'b00;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            tick(1);
            cnt++;
        end
        check("perr cycles to idle", cnt, GAP + 1);
        cpu_ram_wren = 1'b0;
        auto_hlda    = 1'b1;
        tick(3);

        check("scoreboard drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
